// File: rtl/input_port_reorder.sv
// Reorder buffer input port.
// Takes BFT packets addressed to PORT_No, parks each payload in the slot named
// by its sequence address, and hands the payloads to the user strictly in
// address order over a valid/ack handshake. Every FREESPACE_UPDATE_SIZE
// consumed words it emits a one-cycle credit packet back to the sender.
module input_port_reorder #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int PORT_No               = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    input  logic [NUM_LEAF_BITS-1:0] src_leaf,
    input  logic [NUM_PORT_BITS-1:0] src_port,
    output logic [PACKET_BITS-1:0]   packet_from_input_port,
    output logic                     freespace_update,
    output logic [PAYLOAD_BITS-1:0]  dout2user,
    output logic                     vld2user,
    input  logic                     ack_user2b_in,
    output logic [NUM_ADDR_BITS:0]   occupancy,
    output logic                     collision_err
);

    localparam int DEPTH    = 2 ** NUM_ADDR_BITS;
    localparam int LEAF_LO  = PACKET_BITS - 1 - NUM_LEAF_BITS;
    localparam int PORT_LO  = LEAF_LO - NUM_PORT_BITS;
    localparam int CNT_BITS = NUM_ADDR_BITS + 1;

    localparam logic [CNT_BITS-1:0] CREDIT_LAST = CNT_BITS'(FREESPACE_UPDATE_SIZE - 1);

    // Storage and per-slot occupancy flags.
    logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]         slot_vld;

    // rd_ptr names the word sitting in the output register (next to be consumed);
    // fetch_ptr names the next slot to pull into the prefetch stage.
    logic [NUM_ADDR_BITS-1:0] rd_ptr;
    logic [NUM_ADDR_BITS-1:0] fetch_ptr;

    // Prefetch stage holding the registered memory read.
    logic                     s1_vld;
    logic [PAYLOAD_BITS-1:0]  s1_data;

    logic [CNT_BITS-1:0]      credit_cnt;

    // Decoded packet fields and per-cycle control.
    logic                     pkt_vld;
    logic [NUM_PORT_BITS-1:0] pkt_port;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic [PAYLOAD_BITS-1:0]  wr_data;
    logic                     accept;
    logic                     wr_en;
    logic                     collide;
    logic                     handshake;
    logic                     out_load;
    logic                     fetch;
    logic                     lap_block;

    // The leaf field and the fill bits are not needed to accept a packet.
    logic unused_fields;
    assign unused_fields = ^din_leaf_bft2interface[PACKET_BITS-2:LEAF_LO]
                         ^ ^din_leaf_bft2interface[PORT_LO-1:PAYLOAD_BITS+NUM_ADDR_BITS];

    // Decode the incoming packet and derive write/read control for this cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        pkt_vld   = din_leaf_bft2interface[PACKET_BITS-1];
        pkt_port  = din_leaf_bft2interface[PORT_LO +: NUM_PORT_BITS];
        wr_addr   = din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
        wr_data   = din_leaf_bft2interface[PAYLOAD_BITS-1:0];

        accept    = pkt_vld && (pkt_port == NUM_PORT_BITS'(PORT_No));
        wr_en     = accept && !slot_vld[wr_addr];
        collide   = accept &&  slot_vld[wr_addr];

        handshake = vld2user && ack_user2b_in;
        // Output register can take a new word when empty or being consumed now.
        out_load  = !vld2user || ack_user2b_in;

        // With words in flight, fetch_ptr == rd_ptr means fetch_ptr has lapped
        // the ring and is looking at the word already being delivered.
        lap_block = (fetch_ptr == rd_ptr) && (vld2user || s1_vld);
        fetch     = slot_vld[fetch_ptr] && !lap_block && (!s1_vld || out_load);
    end

    // Payload storage and the one-cycle-latency read into the prefetch stage.
    // NOTE: the data array carries no reset; slot_vld alone says what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (fetch) begin
            s1_data <= mem[fetch_ptr];
        end
    end

    // Control state: slot flags, pointers, output register, counters, credit.
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld         <= '0;
            rd_ptr           <= '0;
            fetch_ptr        <= '0;
            s1_vld           <= 1'b0;
            vld2user         <= 1'b0;
            dout2user        <= '0;
            occupancy        <= '0;
            credit_cnt       <= '0;
            freespace_update <= 1'b0;
            collision_err    <= 1'b0;
        end else begin
            // Write and consume never target the same slot: a write needs an
            // empty flag while the consumed slot's flag is still set.
            if (wr_en) begin
                slot_vld[wr_addr] <= 1'b1;
            end
            if (handshake) begin
                slot_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end

            if (fetch) begin
                fetch_ptr <= fetch_ptr + 1'b1;
                s1_vld    <= 1'b1;
            end else if (out_load) begin
                s1_vld    <= 1'b0;
            end

            if (out_load) begin
                vld2user <= s1_vld;
                if (s1_vld) begin
                    dout2user <= s1_data;
                end
            end

            case ({wr_en, handshake})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            if (collide) begin
                collision_err <= 1'b1;
            end

            freespace_update <= 1'b0;
            if (handshake) begin
                if (credit_cnt == CREDIT_LAST) begin
                    credit_cnt       <= '0;
                    freespace_update <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
            end
        end
    end

    // Credit packet is driven only while the strobe is high, all-zero otherwise.
    always_comb begin
        packet_from_input_port = '0;
        if (freespace_update) begin
            packet_from_input_port[PACKET_BITS-1]              = 1'b1;
            packet_from_input_port[LEAF_LO +: NUM_LEAF_BITS]   = src_leaf;
            packet_from_input_port[PORT_LO +: NUM_PORT_BITS]   = src_port;
            packet_from_input_port[PAYLOAD_BITS-1:0]           = PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE);
        end
    end

endmodule

// File: tb/tb_input_port_reorder.sv
// Directed bench for input_port_reorder: a vector table for the basic fill and
// filtering behaviour, plus hand-written sequences for reordering, collision,
// credit pulses, pointer wrap under backpressure and reset mid-stream.
module tb_input_port_reorder;

    localparam int PB  = 97;
    localparam int NLB = 6;
    localparam int NPB = 4;
    localparam int NAB = 3;
    localparam int PL  = 64;
    localparam int FUS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PB-1:0]   din = '0;
    logic [NLB-1:0]  src_leaf = 6'h2A;
    logic [NPB-1:0]  src_port = 4'h5;
    logic [PB-1:0]   packet_from_input_port;
    logic            freespace_update;
    logic [PL-1:0]   dout2user;
    logic            vld2user;
    logic            ack = 1'b0;
    logic [NAB:0]    occupancy;
    logic            collision_err;

    int n_chk = 0;
    int n_err = 0;

    logic [PL-1:0] exp_q[$];

    typedef struct {
        logic          in_vld;
        logic [3:0]    port;
        logic [2:0]    addr;
        logic [63:0]   payload;
        logic          ack;
        logic          exp_vld;
        logic [63:0]   exp_dout;
        logic [3:0]    exp_occ;
        logic          exp_fs;
    } vec_t;

    vec_t vecs[9];

    input_port_reorder #(
        .PACKET_BITS           (PB),
        .NUM_LEAF_BITS         (NLB),
        .NUM_PORT_BITS         (NPB),
        .NUM_ADDR_BITS         (NAB),
        .PAYLOAD_BITS          (PL),
        .PORT_No               (2),
        .FREESPACE_UPDATE_SIZE (FUS)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .din_leaf_bft2interface (din),
        .src_leaf               (src_leaf),
        .src_port               (src_port),
        .packet_from_input_port (packet_from_input_port),
        .freespace_update       (freespace_update),
        .dout2user              (dout2user),
        .vld2user               (vld2user),
        .ack_user2b_in          (ack),
        .occupancy              (occupancy),
        .collision_err          (collision_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk_pkt(input logic v, input logic [3:0] port,
                                             input logic [2:0] addr, input logic [63:0] pl);
        logic [PB-1:0] p;
        p         = '0;
        p[96]     = v;
        p[95:90]  = 6'h11;
        p[89:86]  = port;
        p[66:64]  = addr;
        p[63:0]   = pl;
        return p;
    endfunction

    function automatic logic [PB-1:0] credit_pkt();
        logic [PB-1:0] p;
        p         = '0;
        p[96]     = 1'b1;
        p[95:90]  = 6'h2A;
        p[89:86]  = 4'h5;
        p[63:0]   = 64'd4;
        return p;
    endfunction

    // Advance one edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [63:0] pl);
        din = mk_pkt(1'b1, 4'd2, addr, pl);
    endtask

    task automatic idle();
        din = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_vld", vld2user, 1'b0);
        check("rst_dout", dout2user, 64'h0);
        check("rst_occ", occupancy, 4'd0);
        check("rst_fs", freespace_update, 1'b0);
        check("rst_pkt", packet_from_input_port, '0);
        check("rst_coll", collision_err, 1'b0);
    endtask

    // Consume everything in exp_q in order, optionally toggling ack, checking
    // that a word held under ack=0 does not change.
    task automatic drain(input bit toggle, input int budget);
        int            cyc;
        logic          hold;
        logic [PL-1:0] held;
        logic [PL-1:0] w;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        while (exp_q.size() > 0 && cyc < budget) begin
            ack = toggle ? (cyc % 2 == 0) : 1'b1;
            if (hold) begin
                check("hold_vld", vld2user, 1'b1);
                check("hold_dout", dout2user, held);
            end
            if (vld2user && ack) begin
                w = exp_q.pop_front();
                check("drain_word", dout2user, w);
            end
            hold = vld2user && !ack;
            held = dout2user;
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        ack = 1'b0;
    endtask

    initial begin
        // in_vld port addr payload ack | exp_vld exp_dout exp_occ exp_fs
        vecs[0] = '{1'b1, 4'd2, 3'd0, 64'hA0, 1'b1, 1'b0, 64'h0,  4'd1, 1'b0};
        vecs[1] = '{1'b1, 4'd2, 3'd1, 64'hA1, 1'b1, 1'b0, 64'h0,  4'd2, 1'b0};
        vecs[2] = '{1'b1, 4'd2, 3'd2, 64'hA2, 1'b1, 1'b1, 64'hA0, 4'd3, 1'b0};
        vecs[3] = '{1'b1, 4'd2, 3'd3, 64'hA3, 1'b1, 1'b1, 64'hA1, 4'd3, 1'b0};
        vecs[4] = '{1'b0, 4'd2, 3'd0, 64'h0,  1'b1, 1'b1, 64'hA2, 4'd2, 1'b0};
        vecs[5] = '{1'b0, 4'd0, 3'd0, 64'h0,  1'b1, 1'b1, 64'hA3, 4'd1, 1'b0};
        vecs[6] = '{1'b0, 4'd0, 3'd0, 64'h0,  1'b1, 1'b0, 64'h0,  4'd0, 1'b1};
        vecs[7] = '{1'b1, 4'd3, 3'd0, 64'hEE, 1'b1, 1'b0, 64'h0,  4'd0, 1'b0};
        vecs[8] = '{1'b0, 4'd2, 3'd0, 64'hFF, 1'b1, 1'b0, 64'h0,  4'd0, 1'b0};

        // In-order fill, credit after the 4th word, filtering.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            din = mk_pkt(vecs[i].in_vld, vecs[i].port, vecs[i].addr, vecs[i].payload);
            ack = vecs[i].ack;
            tick();
            check($sformatf("v%0d_vld", i), vld2user, vecs[i].exp_vld);
            check($sformatf("v%0d_occ", i), occupancy, vecs[i].exp_occ);
            check($sformatf("v%0d_fs", i), freespace_update, vecs[i].exp_fs);
            if (vecs[i].exp_vld) check($sformatf("v%0d_dout", i), dout2user, vecs[i].exp_dout);
            if (vecs[i].exp_fs) check($sformatf("v%0d_pkt", i), packet_from_input_port, credit_pkt());
        end
        idle();

        // Out-of-order: addr 1 waits for addr 0.
        do_reset();
        ack = 1'b1;
        wr(3'd1, 64'hB1);
        tick();
        check("ooo_occ1", occupancy, 4'd1);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ooo_stall", vld2user, 1'b0);
        end
        wr(3'd0, 64'hB0);
        tick();
        check("ooo_occ2", occupancy, 4'd2);
        idle();
        tick();
        check("ooo_lat1", vld2user, 1'b0);
        tick();
        check("ooo_vld0", vld2user, 1'b1);
        check("ooo_d0", dout2user, 64'hB0);
        tick();
        check("ooo_vld1", vld2user, 1'b1);
        check("ooo_d1", dout2user, 64'hB1);
        check("ooo_occ3", occupancy, 4'd1);
        tick();
        check("ooo_end_vld", vld2user, 1'b0);
        check("ooo_end_occ", occupancy, 4'd0);

        // Collision keeps the first payload and is sticky.
        do_reset();
        wr(3'd5, 64'hC5);
        tick();
        check("col_none", collision_err, 1'b0);
        wr(3'd5, 64'hDD);
        tick();
        check("col_set", collision_err, 1'b1);
        check("col_occ", occupancy, 4'd1);
        for (int i = 0; i < 5; i++) begin
            wr(3'(i), 64'h50 + 64'(i));
            tick();
        end
        idle();
        check("col_occ6", occupancy, 4'd6);
        exp_q = '{64'h50, 64'h51, 64'h52, 64'h53, 64'h54, 64'hC5};
        drain(1'b0, 40);
        tick();
        check("col_sticky", collision_err, 1'b1);
        check("col_occ0", occupancy, 4'd0);

        // Credit: 8 words -> two pulses, each the cycle after the 4th/8th handshake.
        do_reset();
        begin
            int   hs_total;
            int   pulses;
            logic hs_now;
            hs_total = 0;
            pulses   = 0;
            ack      = 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (c < 8) wr(3'(c), 64'h60 + 64'(c));
                else idle();
                hs_now = vld2user && ack;
                tick();
                if (hs_now) hs_total++;
                check("cr_fs", freespace_update, hs_now && (hs_total % FUS == 0));
                if (freespace_update) begin
                    pulses++;
                    check("cr_pkt", packet_from_input_port, credit_pkt());
                end else begin
                    check("cr_pkt_zero", packet_from_input_port, '0);
                end
            end
            check("cr_pulses", pulses, 2);
            check("cr_words", hs_total, 8);
        end

        // Wrap and backpressure: fill all 8 slots, then drain with ack
        // toggling while refilling addresses 0..3 as they free up.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 64'h70 + 64'(i));
            tick();
        end
        idle();
        check("wrap_full", occupancy, 4'd8);
        begin
            logic [PL-1:0] exp_w[12];
            int            k;
            int            next2;
            int            hs_total;
            int            cyc;
            logic          hs_now;
            logic          hold;
            logic [PL-1:0] held;
            for (int i = 0; i < 8; i++) exp_w[i] = 64'h70 + 64'(i);
            for (int i = 0; i < 4; i++) exp_w[8 + i] = 64'h80 + 64'(i);
            k = 0; next2 = 0; hs_total = 0; cyc = 0; hold = 1'b0; held = '0;
            while (k < 12 && cyc < 100) begin
                ack = (cyc % 2 == 0);
                if (next2 < 4 && hs_total > next2) begin
                    wr(3'(next2), 64'h80 + 64'(next2));
                    next2++;
                end else begin
                    idle();
                end
                if (hold) begin
                    check("wrap_hold_vld", vld2user, 1'b1);
                    check("wrap_hold_dout", dout2user, held);
                end
                hs_now = vld2user && ack;
                if (hs_now) begin
                    check($sformatf("wrap_w%0d", k), dout2user, exp_w[k]);
                    k++;
                end
                hold = vld2user && !ack;
                held = dout2user;
                tick();
                if (hs_now) hs_total++;
                cyc++;
            end
            if (k != 12) check("wrap_timeout", k, 12);
        end
        idle();
        ack = 1'b0;
        tick();
        check("wrap_occ0", occupancy, 4'd0);
        check("wrap_nocoll", collision_err, 1'b0);

        // Reset mid-stream with words buffered and one presented.
        do_reset();
        wr(3'd0, 64'hD0);
        tick();
        wr(3'd1, 64'hD1);
        tick();
        wr(3'd2, 64'hD2);
        tick();
        idle();
        check("mid_vld", vld2user, 1'b1);
        check("mid_occ", occupancy, 4'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_vld", vld2user, 1'b0);
        check("mid_rst_occ", occupancy, 4'd0);
        ack = 1'b1;
        wr(3'd0, 64'hE0);
        tick();
        idle();
        check("fresh_occ", occupancy, 4'd1);
        check("fresh_nocoll", collision_err, 1'b0);
        tick();
        check("fresh_lat", vld2user, 1'b0);
        tick();
        check("fresh_vld", vld2user, 1'b1);
        check("fresh_dout", dout2user, 64'hE0);
        tick();
        check("fresh_end", occupancy, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/input_port_reorder.md
Name: input_port_reorder

Overview:
- Parametrised successor of the leaf-interface input port: receives BFT packets addressed to this port and stores payloads in a reorder buffer indexed by the packet's sequence address.
- Delivers payloads to the user strictly in address order through a valid/ack handshake.
- Returns batched freespace credits to the sender as a packet.
- Buffer depth, width, credit batch size and filtering are all parameters. The block sits between the leaf BFT interface and user logic.

Parameters:
- PACKET_BITS, 97, total packet width.
- NUM_LEAF_BITS, 6, leaf id field width.
- NUM_PORT_BITS, 4, port field width.
- NUM_ADDR_BITS, 7, sequence address width; buffer depth = 2**NUM_ADDR_BITS slots.
- PAYLOAD_BITS, 64, payload width.
- PORT_No, 2, port id this block accepts.
- FREESPACE_UPDATE_SIZE, 64, words consumed per credit packet; 1..2**NUM_ADDR_BITS.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- din_leaf_bft2interface  in  PACKET_BITS  incoming packet. Field layout:
  - [PACKET_BITS-1] valid.
  - Leaf field below valid.
  - Port field below leaf.
  - Address at [PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS].
  - Payload at [PAYLOAD_BITS-1:0].
- src_leaf  in  NUM_LEAF_BITS  leaf id inserted into credit packets.
- src_port  in  NUM_PORT_BITS  port id inserted into credit packets.
- packet_from_input_port  out  PACKET_BITS  credit packet.
- freespace_update  out  1  one-cycle credit strobe.
- dout2user  out  PAYLOAD_BITS  data to user.
- vld2user  out  1  data valid.
- ack_user2b_in  in  1  user accept.
- occupancy  out  NUM_ADDR_BITS+1  number of slots currently holding data.
- collision_err  out  1  sticky; set on a write to an occupied slot.

Behaviour:
- Reset state: all slot-valid flags 0, rd_ptr=0, credit_cnt=0, occupancy=0. All outputs read 0 after reset, including packet_from_input_port.
- Accept rule: a packet is accepted when valid=1 and port field==PORT_No. Other packets are ignored with no state change.
- Write on accept:
  - If slot[addr] is empty: store the payload, set slot_vld[addr] at the next edge, increment occupancy.
  - If slot[addr] is occupied: drop the packet, set collision_err (cleared only by reset); occupancy and the stored data are unchanged.
- Read side: a prefetch stage is loaded when the output register is free or being acked this cycle and slot_vld[rd_ptr]=1.
  - Memory read latency is 1 cycle. A slot written at edge N is visible at edge N+1, so vld2user rises at the edge after N+1 at the earliest (2 cycles after acceptance).
- Output handshake:
  - vld2user and dout2user hold stable until the cycle vld2user&&ack_user2b_in is true.
  - On that handshake: clear slot_vld[rd_ptr-of-that-word], decrement occupancy, and advance rd_ptr modulo 2**NUM_ADDR_BITS (wraps from max to 0).
  - Back-to-back: with consecutive slots filled and ack held high, one word per cycle.
- Simultaneous write and consume in the same cycle: occupancy stays unchanged. A write to the slot being freed in that same cycle counts as a collision, because the flag is still set.
- Ordering: a gap at rd_ptr stalls delivery even if later slots are filled. No timeout.
- Credit counter:
  - credit_cnt increments on each handshake.
  - When it equals FREESPACE_UPDATE_SIZE-1 and a handshake occurs, it returns to 0 and freespace_update pulses high for exactly the next cycle.
  - During the pulse, packet_from_input_port = {1'b1, src_leaf, src_port, zero fill, payload=FREESPACE_UPDATE_SIZE}.
  - Outside the pulse, packet_from_input_port is all-zero.
- Reset mid-operation: all buffered data is discarded, any pending credit is lost, vld2user drops the cycle after reset is sampled.
- Widths: occupancy saturates naturally at 2**NUM_ADDR_BITS, since a full buffer makes every write a collision.

Test Plan:
- In-order fill: PORT_No=2, addresses 0..3 with payloads 0xA0..0xA3, ack held 1 -> dout2user 0xA0..0xA3 on consecutive cycles, first vld2user 2 cycles after acceptance; occupancy returns to 0.
- Out-of-order: write addr 1 (0xB1) then addr 0 (0xB0) -> no vld2user until addr 0 is written; then 0xB0 followed by 0xB1.
- Filtering and collision:
  - A port=3 packet is ignored: occupancy stays 0.
  - Writing addr 5 twice without consuming sets collision_err=1 and keeps the first payload.
- Credit: FREESPACE_UPDATE_SIZE=4; deliver 8 words -> exactly two single-cycle freespace_update pulses, each one cycle after the 4th and 8th handshakes. Packet valid=1, src fields match, payload=4.
- Wrap and backpressure: NUM_ADDR_BITS=3, stream addresses 0..7,0..3 with ack toggling 1/0 -> all 12 words in order; dout2user stable while ack=0; rd_ptr wraps 7->0.
- Reset mid-stream: assert reset with 3 words buffered and vld2user=1 -> vld2user=0 and occupancy=0 the next cycle; afterwards addr 0 is accepted as fresh.
